ex_stage: RTL
=============

Name: ex_stage

Overview:
- Execute stage that consumes the ID/EX pipeline register outputs.
- Resolves operand forwarding, decodes ALU control from aluop and funct, and computes the result.
- Runs an iterative 32-cycle multiplier for MUL and stalls the front end while it runs.
- Registers results into an internal EX/MEM pipeline register that feeds the memory stage.

Parameters:
- MUL_CYCLES, 32, number of shift-add iterations for MUL (fixed at 32 for 32-bit operands).

Ports:
- clk_i input 1: clock, rising edge.
- rst_i input 1: synchronous, active-high reset.
- regdst_i, alusrc_i, memtoreg_i, regwrite_i, memread_i, memwrite_i input 1 each: control from ID/EX.
- aluop_i input 2: ALU class from ID/EX.
- RS_i, RT_i input 32: register operands from ID/EX.
- signextend_i input 32: immediate; bits [5:0] are funct for R-type.
- RSaddr_i, RTaddr_i, RDaddr_i input 5: register addresses from ID/EX.
- memwb_regwrite_i input 1: MEM/WB write enable, for forwarding.
- memwb_rd_i input 5: MEM/WB destination.
- memwb_data_i input 32: MEM/WB writeback data.
- stall_o output 1: freeze PC, IF/ID and ID/EX this cycle.
- memtoreg_o, regwrite_o, memread_o, memwrite_o output 1 each: EX/MEM control.
- aluresult_o output 32: EX/MEM ALU result or memory address.
- wdata_o output 32: EX/MEM store data (forwarded RT).
- rd_o output 5: EX/MEM destination register.

Behaviour:
- Reset: all EX/MEM outputs 0, stall_o 0, FSM IDLE, multiplier state cleared.
- Reset has priority over everything. Reset mid-MUL aborts the operation, returns to IDLE, and produces no writeback.
- Forwarding, per operand A (RSaddr_i) and operand B (RTaddr_i):
  - First choice: EX/MEM, when regwrite_o=1, rd_o!=0 and rd_o==addr. Uses aluresult_o.
  - Else MEM/WB, when memwb_regwrite_i=1, memwb_rd_i!=0 and memwb_rd_i==addr. Uses memwb_data_i.
  - Else the ID/EX value.
- Operand B = alusrc_i ? signextend_i : forwarded RT. wdata_o always takes forwarded RT.
- Destination = regdst_i ? RDaddr_i : RTaddr_i.
- ALU control:
  - aluop 00 and 11: ADD. aluop 01: SUB.
  - aluop 10, funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT (signed, result 0 or 1), 0x18 MUL.
  - aluop 10 with any other funct: ADD.
- Arithmetic wraps modulo 2^32; no overflow trap. MUL returns the low 32 bits of the product, so the result is identical for signed and unsigned operands.
- Single-cycle ops have latency 1: operands at ID/EX output in cycle T appear on EX/MEM outputs after edge T.
- FSM states IDLE, MUL, DONE:
  - IDLE: if the decoded op is MUL and regwrite_i=1, capture both forwarded operands, set stall_o=1 combinationally, load EX/MEM with a bubble (all four control outputs 0; data outputs don't-care, hold), then go to MUL with count=0.
  - MUL: stall_o=1. One shift-add iteration per cycle, EX/MEM loads a bubble each edge. When count==MUL_CYCLES-1, go to DONE.
  - DONE: stall_o=0. EX/MEM loads the product with the instruction's control bits and destination, then go to IDLE.
- MUL timing:
  - Entry at cycle T; stall_o is high for cycles T..T+32 (33 cycles).
  - The result is on the outputs after edge T+33.
- Operands are captured at entry. MEM/WB changes during the stall do not affect the product.
- Forwarding from EX/MEM during a stall sees only bubbles (regwrite_o=0). This is correct because the previous instruction has already advanced.
- A MUL with regwrite_i=0 is treated as a single-cycle bubble; no stall.
- Back-to-back MULs: the second enters IDLE the cycle after DONE. It forwards the first MUL's result from EX/MEM.
- In DONE the stage ignores a new MUL on its inputs; ID/EX was frozen, so the inputs still hold the same instruction.

Decomposition:
- Shared package/include ex_defs:
  - ALU op codes: ADD, SUB, AND, OR, SLT, MUL.
  - funct constants 0x20, 0x22, 0x24, 0x25, 0x2A, 0x18.
  - aluop encodings.
  - FSM state encodings IDLE, MUL, DONE.
- One sub-module, mul_iter: start/busy/done handshake, 32-bit multiplicand and multiplier in, 32-bit product out, one shift-add per cycle.
- Forwarding muxes, ALU, FSM and the EX/MEM register stay in ex_stage.

Test Plan:
- Forward priority: EX/MEM rd_o=5 with aluresult 0x11 and MEM/WB rd=5 with data 0x22, RSaddr=5, ADD with RT=1 -> aluresult_o=0x12. Repeat with EX/MEM regwrite_o=0 -> 0x23.
- r0 guard: memwb_rd=0, memwb_regwrite=1, data 0xFF, RSaddr=0, RS_i=0, ADD with RT=4 -> aluresult_o=4.
- SLT signed: RS=0xFFFFFFFF, RT=1, funct 0x2A -> aluresult_o=1. Swap operands -> 0.
- MUL 7*6, rd=3: stall_o high exactly 33 cycles, EX/MEM shows regwrite_o=0 during the stall, then aluresult_o=42, rd_o=3, regwrite_o=1.
- MUL 0xFFFFFFFF*3 -> aluresult_o=0xFFFFFFFD. Follow with back-to-back ADD using that rd -> forwarded sum correct.
- rst_i asserted at cycle 10 of a MUL -> next cycle stall_o=0 and all outputs 0; no MUL result ever appears with regwrite_o=1.

Source files
------------

// File: rtl/ex_defs_pkg.sv
// Shared encodings for the execute stage: ALU operations, funct/aluop codes,
// FSM states and the EX/MEM load selector.
package ex_defs;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_MUL
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_MUL = 6'h18;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ADD2  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DONE
  } ex_state_e;

  typedef enum logic [1:0] {
    LD_ALU,
    LD_BUBBLE,
    LD_MUL
  } ld_sel_e;

  function automatic alu_op_e alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
    alu_op_e op;
    op = ALU_ADD;
    if (aluop == ALUOP_SUB) begin
      op = ALU_SUB;
    end else if (aluop == ALUOP_RTYPE) begin
      case (funct)
        FUNCT_ADD: op = ALU_ADD;
        FUNCT_SUB: op = ALU_SUB;
        FUNCT_AND: op = ALU_AND;
        FUNCT_OR:  op = ALU_OR;
        FUNCT_SLT: op = ALU_SLT;
        FUNCT_MUL: op = ALU_MUL;
        default:   op = ALU_ADD;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/ex_stage_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, low 32 bits kept.
module mul_iter #(
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] mcand_i,
  input  logic [31:0] mplier_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] product_o
);

  localparam int unsigned CW = $clog2(MUL_CYCLES);

  logic [31:0]   mcand_q;
  logic [31:0]   mplier_q;
  logic [31:0]   acc_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start_i && !busy_q) begin
      mcand_q  <= mcand_i;
      mplier_q <= mplier_i;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end

  // done_o marks the cycle whose edge performs the final iteration;
  // product_o is complete from the following cycle on.
  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == CW'(MUL_CYCLES - 1));
  assign product_o = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, iterative MUL with front-end stall,
// and the EX/MEM pipeline register.
module ex_stage
  import ex_defs::*;
#(
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        regdst_i,
  input  logic        alusrc_i,
  input  logic        memtoreg_i,
  input  logic        regwrite_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [1:0]  aluop_i,
  input  logic [31:0] RS_i,
  input  logic [31:0] RT_i,
  input  logic [31:0] signextend_i,
  input  logic [4:0]  RSaddr_i,
  input  logic [4:0]  RTaddr_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        memwb_regwrite_i,
  input  logic [4:0]  memwb_rd_i,
  input  logic [31:0] memwb_data_i,
  output logic        stall_o,
  output logic        memtoreg_o,
  output logic        regwrite_o,
  output logic        memread_o,
  output logic        memwrite_o,
  output logic [31:0] aluresult_o,
  output logic [31:0] wdata_o,
  output logic [4:0]  rd_o
);

  alu_op_e     alu_op;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic [4:0]  dest;

  ex_state_e   state_q;
  ex_state_e   state_d;
  ld_sel_e     ld_sel;
  logic        mul_start;
  logic        mul_busy;
  logic        mul_done;
  logic [31:0] mul_prod;

  assign alu_op = alu_decode(aluop_i, signextend_i[5:0]);

  always_comb begin
    fwd_a = RS_i;
    if (regwrite_o && rd_o != '0 && rd_o == RSaddr_i) fwd_a = aluresult_o;
    else if (memwb_regwrite_i && memwb_rd_i != '0 && memwb_rd_i == RSaddr_i) fwd_a = memwb_data_i;

    fwd_b = RT_i;
    if (regwrite_o && rd_o != '0 && rd_o == RTaddr_i) fwd_b = aluresult_o;
    else if (memwb_regwrite_i && memwb_rd_i != '0 && memwb_rd_i == RTaddr_i) fwd_b = memwb_data_i;

    op_b = alusrc_i ? signextend_i : fwd_b;
    dest = regdst_i ? RDaddr_i : RTaddr_i;
  end

  always_comb begin
    alu_res = fwd_a + op_b;
    case (alu_op)
      ALU_SUB: alu_res = fwd_a - op_b;
      ALU_AND: alu_res = fwd_a & op_b;
      ALU_OR:  alu_res = fwd_a | op_b;
      ALU_SLT: alu_res = {31'b0, ($signed(fwd_a) < $signed(op_b))};
      default: alu_res = fwd_a + op_b;
    endcase
  end

  mul_iter #(
    .MUL_CYCLES(MUL_CYCLES)
  ) u_mul (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (mul_start),
    .mcand_i  (fwd_a),
    .mplier_i (op_b),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_prod)
  );

  // In DONE the inputs still hold the frozen MUL, so it is retired rather than restarted.
  always_comb begin
    state_d   = state_q;
    stall_o   = 1'b0;
    mul_start = 1'b0;
    ld_sel    = LD_ALU;
    case (state_q)
      ST_IDLE: begin
        if (alu_op == ALU_MUL) begin
          ld_sel = LD_BUBBLE;
          if (regwrite_i && !mul_busy) begin
            mul_start = 1'b1;
            stall_o   = 1'b1;
            state_d   = ST_MUL;
          end
        end
      end
      ST_MUL: begin
        stall_o = 1'b1;
        ld_sel  = LD_BUBBLE;
        if (mul_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        ld_sel  = LD_MUL;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst_i) begin
      stall_o   = 1'b0;
      mul_start = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      memtoreg_o  <= 1'b0;
      regwrite_o  <= 1'b0;
      memread_o   <= 1'b0;
      memwrite_o  <= 1'b0;
      aluresult_o <= '0;
      wdata_o     <= '0;
      rd_o        <= '0;
    end else begin
      state_q <= state_d;
      case (ld_sel)
        LD_ALU, LD_MUL: begin
          memtoreg_o  <= memtoreg_i;
          regwrite_o  <= regwrite_i;
          memread_o   <= memread_i;
          memwrite_o  <= memwrite_i;
          aluresult_o <= (ld_sel == LD_MUL) ? mul_prod : alu_res;
          wdata_o     <= fwd_b;
          rd_o        <= dest;
        end
        default: begin
          memtoreg_o <= 1'b0;
          regwrite_o <= 1'b0;
          memread_o  <= 1'b0;
          memwrite_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
